// File: rtl/reverse_ctrl.sv
// Sequencer for the digit-reversal datapath: loads x, steps one decimal digit
// per cycle until x reaches zero, then commits the result or flags the iteration limit.
module reverse_ctrl #(
  parameter int unsigned MAX_ITER = 5,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             x_eq,
  output logic             st,
  output logic             ld_x,
  output logic             ld_re,
  output logic             ld_out,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] digits
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

  state_t           state, next;
  logic [CNT_W-1:0] iter;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      iter   <= '0;
      digits <= '0;
      err    <= 1'b0;
    end else begin
      state <= next;
      case (state)
        IDLE: begin
          if (start) begin
            iter <= '0;
            err  <= 1'b0;
          end
        end
        CALC: begin
          // x_eq wins over the limit so an exact MAX_ITER-digit value still commits
          if (x_eq) begin
            digits <= iter;
          end else if (iter == MAX_CNT) begin
            err    <= 1'b1;
            digits <= iter;
          end else begin
            iter <= iter + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next   = state;
    st     = 1'b0;
    ld_x   = 1'b0;
    ld_re  = 1'b0;
    ld_out = 1'b0;
    ready  = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          ld_x  = 1'b1;
          ld_re = 1'b1;
          next  = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (x_eq) begin
          ld_out = 1'b1;
          next   = DONE;
        end else if (iter == MAX_CNT) begin
          next = DONE;
        end else begin
          st    = 1'b1;
          ld_x  = 1'b1;
          ld_re = 1'b1;
        end
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reverse_ctrl.sv
// Directed bench for reverse_ctrl: two instances (default and MAX_ITER=2), each
// driving a small behavioural model of the regX/regRE/regO datapath.
module tb_reverse_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst, start, x_eq, st, ld_x, ld_re, ld_out, ready, busy, done, err;
  logic [3:0] digits0, digits1;
  logic [1:0][15:0] x_in, rx, rre, ro;

  reverse_ctrl u_dut (
    .clk(clk), .rst(rst[0]), .start(start[0]), .x_eq(x_eq[0]),
    .st(st[0]), .ld_x(ld_x[0]), .ld_re(ld_re[0]), .ld_out(ld_out[0]),
    .ready(ready[0]), .busy(busy[0]), .done(done[0]), .err(err[0]),
    .digits(digits0)
  );

  reverse_ctrl #(.MAX_ITER(2), .CNT_W(4)) u_dut_lim (
    .clk(clk), .rst(rst[1]), .start(start[1]), .x_eq(x_eq[1]),
    .st(st[1]), .ld_x(ld_x[1]), .ld_re(ld_re[1]), .ld_out(ld_out[1]),
    .ready(ready[1]), .busy(busy[1]), .done(done[1]), .err(err[1]),
    .digits(digits1)
  );

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst[g]) begin
        rx[g]  <= '0;
        rre[g] <= '0;
        ro[g]  <= '0;
      end else begin
        if (ld_x[g])   rx[g]  <= st[g] ? rx[g] / 16'd10 : x_in[g];
        if (ld_re[g])  rre[g] <= st[g] ? rre[g] * 16'd10 + rx[g] % 16'd10 : 16'd0;
        if (ld_out[g]) ro[g]  <= rre[g];
      end
    end
  end
  assign x_eq[0] = (rx[0] == 16'd0);
  assign x_eq[1] = (rx[1] == 16'd0);

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int   ld_first, done_first, ld_cnt, done_cnt, acc_cnt, restart_cyc;
  logic err_done, c0_ok;

  // Cycle c is sampled just before the edge that ends it; cycle 0 ends at the start edge.
  task automatic run_op(input int g, input logic [15:0] xv, input int hold, input int ncyc);
    @(negedge clk);
    x_in[g] = xv;
    start[g] = 1'b1;
    ld_first = -1; done_first = -1; ld_cnt = 0; done_cnt = 0;
    acc_cnt = 0; restart_cyc = -1; err_done = 1'bx; c0_ok = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (c >= hold) start[g] = 1'b0;
      #1;
      if (c == 0) c0_ok = ready[g] & ld_x[g] & ld_re[g] & ~st[g] & ~busy[g];
      if (ld_out[g]) begin
        ld_cnt++;
        if (ld_first < 0) ld_first = c;
      end
      if (done[g]) begin
        done_cnt++;
        if (done_first < 0) begin
          done_first = c;
          err_done = err[g];
        end
      end
      if (ready[g] && start[g]) begin
        acc_cnt++;
        if (c > 0 && restart_cyc < 0) restart_cyc = c;
      end
      @(negedge clk);
    end
    start[g] = 1'b0;
  endtask

  initial begin
    rst = 2'b00; start = 2'b00; x_in = '0;

    // T1: reset held for two edges
    @(posedge clk); @(posedge clk); #1;
    check("t1_ready", ready[0], 1);
    check("t1_busy", busy[0], 0);
    check("t1_done", done[0], 0);
    check("t1_err", err[0], 0);
    check("t1_loads", {ld_x[0], ld_re[0], ld_out[0], st[0]}, 0);
    check("t1_digits", digits0, 0);
    @(negedge clk); rst = 2'b11;
    @(posedge clk); #1;
    check("t1_idle_ready", ready[0], 1);
    check("t1_idle_loads", {ld_x[0], ld_re[0], ld_out[0]}, 0);

    // T2: x=1234
    run_op(0, 16'd1234, 1, 10);
    check("t2_c0", c0_ok, 1);
    check("t2_ld_cyc", ld_first, 5);
    check("t2_done_cyc", done_first, 6);
    check("t2_err", err_done, 0);
    check("t2_digits", digits0, 4);
    check("t2_rev", ro[0], 4321);
    check("t2_done_cnt", done_cnt, 1);

    // T3: x=0
    run_op(0, 16'd0, 1, 6);
    check("t3_ld_cyc", ld_first, 1);
    check("t3_done_cyc", done_first, 2);
    check("t3_digits", digits0, 0);
    check("t3_rev", ro[0], 0);

    // x=907 exercises an interior zero digit
    run_op(0, 16'd907, 1, 8);
    check("t3b_ld_cyc", ld_first, 4);
    check("t3b_done_cyc", done_first, 5);
    check("t3b_digits", digits0, 3);
    check("t3b_rev", ro[0], 709);

    // T5: reset mid-operation in cycle 3
    @(negedge clk); x_in[0] = 16'd1234; start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    @(negedge clk);
    @(negedge clk); rst[0] = 1'b0;
    @(posedge clk); #1;
    check("t5_ready", ready[0], 1);
    check("t5_busy", busy[0], 0);
    check("t5_digits", digits0, 0);
    @(negedge clk); rst[0] = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (done[0] || ld_out[0]) done_cnt++;
      @(negedge clk);
    end
    check("t5_no_done", done_cnt, 0);
    check("t5_rev", ro[0], 0);

    // T4: x=65535 with start held for 10 cycles
    run_op(0, 16'd65535, 10, 20);
    check("t4_c0", c0_ok, 1);
    check("t4_ld_cyc", ld_first, 6);
    check("t4_done_cyc", done_first, 7);
    check("t4_restart_cyc", restart_cyc, 8);
    check("t4_accepts", acc_cnt, 2);
    check("t4_ld_cnt", ld_cnt, 2);
    check("t4_done_cnt", done_cnt, 2);
    check("t4_rev", ro[0], 53556);
    check("t4_digits", digits0, 5);

    // T6: MAX_ITER=2 instance
    run_op(1, 16'd77, 1, 8);
    check("t6_pre_ld_cyc", ld_first, 3);
    check("t6_pre_done_cyc", done_first, 4);
    check("t6_pre_err", err_done, 0);
    check("t6_pre_rev", ro[1], 77);
    check("t6_pre_digits", digits1, 2);
    run_op(1, 16'd123, 1, 8);
    check("t6_done_cyc", done_first, 4);
    check("t6_err", err_done, 1);
    check("t6_ld_cnt", ld_cnt, 0);
    check("t6_digits", digits1, 2);
    check("t6_rev", ro[1], 77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
